// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and line-format constants used by
// both the receive and transmit sides.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_SYNC_STAGES  = 2;
    localparam int DATA_BITS            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for an asynchronous level; reset value 1 (idle line).
// Latency STAGES clocks; no handshake, samples every cycle.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '1;
        end else begin
            r_q <= {r_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx_valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after start.
// No backpressure on the line: an unread byte is overwritten and overrun is flagged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX    = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_rxs;
    logic                 w_cnt_zero;
    logic                 w_load;
    logic                 w_frame_err;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_RELOAD;
                end
            end
            START: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_rxs) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = FULL_RELOAD;
                    w_idx_nxt   = '0;
                end else begin
                    // Line went high again before mid start bit: treat as noise.
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt[r_idx] = w_rxs;
                    w_idx_nxt          = r_idx + 3'd1;
                    w_cnt_nxt          = FULL_RELOAD;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Re-arm at mid stop bit so a back-to-back start edge is not missed.
                    w_state_nxt = IDLE;
                    w_load      = w_rxs;
                    w_frame_err = !w_rxs;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (rx_read) begin
                r_rx_valid <= 1'b0;
            end
            // A read landing with the new byte consumes the old one, so it is not an overrun.
            if (w_load && r_rx_valid && !rx_read) begin
                r_overrun <= 1'b1;
            end else if (rx_read) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_busy   = (r_state != IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: reset, latency, glitch, break, mid-frame reset, a vector table
// of handshake cases and randomized frames against a frame-level reference model.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int SS  = 2;
    localparam int LAT = SS + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int g_start = 0;
    int last_vrise = -1;
    int ferr_cnt = 0;
    int ferr_long = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    // Frame-level reference state
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_ferr;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       rd_done;
        logic       rd_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[11];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_read   (rx_read),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled between edges
    always @(posedge clk) begin
        #2;
        if (rx_valid && !prev_v) last_vrise = cyc;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (frame_err && prev_f) ferr_long = ferr_long + 1;
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Called just after a negedge; returns on the negedge following the stop bit.
    // rd_done pulses rx_read so that it is sampled on the byte-completion edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_done);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        g_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int j = 0; j < CPB; j++) begin
                rx_read = rd_done && (cyc == g_start + LAT);
                @(negedge clk);
            end
        end
        rx = 1'b1;
        rx_read = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_data = 8'h00;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic rd);
        if (stop) begin
            if (exp_valid && !rd) exp_ovr = 1'b1;
            else if (rd) exp_ovr = 1'b0;
            exp_data = b;
            exp_valid = 1'b1;
        end else begin
            exp_ferr = exp_ferr + 1;
            if (rd) begin
                exp_valid = 1'b0;
                exp_ovr = 1'b0;
            end
        end
    endtask

    initial begin
        int f0;
        logic [7:0] b;
        logic st, rd, ra, pv;

        vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1]  = '{8'h55, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[3]  = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
        vecs[4]  = '{8'h33, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0};
        vecs[5]  = '{8'h44, 1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1};
        vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
        vecs[8]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[10] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};

        rx = 1'b1;
        rx_read = 1'b0;
        exp_ferr = 0;
        @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_busy", int'(rx_busy), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_ovr", int'(overrun), 0);

        // Basic byte with latency and read handshake
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("basic_latency", last_vrise - g_start - 1, LAT);
        chk("basic_data", int'(rx_data), 'hA5);
        chk("basic_valid", int'(rx_valid), 1);
        chk("basic_ferr_cnt", ferr_cnt, 0);
        chk("basic_ovr", int'(overrun), 0);
        do_read();
        chk("basic_read_clears", int'(rx_valid), 0);
        idle(5);

        // Glitch: 5 clocks low
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy_set", int'(rx_busy), 1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_busy_mid_start", int'(rx_busy), 0);
        idle(200);
        chk("glitch_no_valid", int'(rx_valid), 0);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);

        // Break: line held low for a whole frame
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (10 * CPB) @(negedge clk);
        idle(40);
        chk("break_ferr", ferr_cnt - f0, 1);
        chk("break_valid", int'(rx_valid), 0);
        chk("break_data", int'(rx_data), 'hA5);
        chk("break_busy", int'(rx_busy), 0);

        // Reset during data bit 4
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("pre_reset_valid", int'(rx_valid), 1);
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_data", int'(rx_data), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        chk("midrst_busy", int'(rx_busy), 0);
        chk("midrst_ovr", int'(overrun), 0);
        f0 = ferr_cnt;
        idle(200);
        chk("midrst_no_partial", int'(rx_valid), 0);
        chk("midrst_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        chk("midrst_next_data", int'(rx_data), 'h81);
        chk("midrst_next_valid", int'(rx_valid), 1);
        chk("midrst_next_latency", last_vrise - g_start - 1, LAT);

        // Vector table
        do_reset();
        idle(4);
        for (int i = 0; i < 11; i++) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].din, vecs[i].stop, vecs[i].rd_done);
            chk($sformatf("vec%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_valid", i), int'(rx_valid), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_ovr", i), int'(overrun), int'(vecs[i].exp_ovr));
            chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].stop ? 0 : 1);
            if (vecs[i].rd_after) begin
                do_read();
                chk($sformatf("vec%0d_read_valid", i), int'(rx_valid), 0);
                chk($sformatf("vec%0d_read_ovr", i), int'(overrun), 0);
                idle(3);
            end
            if (!vecs[i].stop) idle(20);
        end

        // Randomized frames against the reference model
        do_reset();
        idle(40);
        exp_ferr = ferr_cnt;
        for (int k = 0; k < 40; k++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            rd = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 2) == 0);
            pv = exp_valid;
            send_frame(b, st, rd);
            model_frame(b, st, rd);
            if (st && !pv) chk($sformatf("rnd%0d_latency", k), last_vrise - g_start - 1, LAT);
            chk($sformatf("rnd%0d_data", k), int'(rx_data), int'(exp_data));
            chk($sformatf("rnd%0d_valid", k), int'(rx_valid), int'(exp_valid));
            chk($sformatf("rnd%0d_ovr", k), int'(overrun), int'(exp_ovr));
            chk($sformatf("rnd%0d_ferr", k), ferr_cnt, exp_ferr);
            if (ra) begin
                do_read();
                chk($sformatf("rnd%0d_read_valid", k), int'(rx_valid), int'(exp_valid));
                chk($sformatf("rnd%0d_read_ovr", k), int'(overrun), int'(exp_ovr));
            end
            if (!st) idle($urandom_range(20, 40));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 10));
        end

        chk("ferr_single_cycle", ferr_long, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
